// File: rtl/riscv_pkg.sv
// riscv_pkg: shared opcodes, the default pipeline depth and the source-usage decode.
package riscv_pkg;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IALU   = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam int PIPE_DEPTH_DEF = 3;
  typedef struct packed {
    logic rs1;
    logic rs2;
  } src_use_t;
  function automatic src_use_t decode_src(input logic [6:0] op);
    src_use_t s;
    s.rs2 = op inside {OP_R, OP_STORE, OP_BRANCH};
    s.rs1 = s.rs2 || (op inside {OP_IALU, OP_LOAD, OP_JALR});
    return s;
  endfunction
endpackage

// File: rtl/scoreboard_entry.sv
// scoreboard_entry: in-flight countdown and load flag for one architectural register.
module scoreboard_entry import riscv_pkg::*; #(
  parameter int PIPE_DEPTH = PIPE_DEPTH_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       set,
  input  logic       set_ld,
  input  logic       dec,
  input  logic       kill,
  output logic [1:0] cnt,
  output logic       ld
);
  localparam logic [1:0] FULL = 2'(PIPE_DEPTH);
  logic [1:0] cnt_q, cnt_d;
  logic       ld_q, ld_d;
  // kill only removes the producer that was about to enter EX
  always_comb begin
    cnt_d = set ? FULL : (kill && cnt_q == FULL) ? 2'd0 : (dec && cnt_q != 2'd0) ? cnt_q - 2'd1 : cnt_q;
    ld_d  = set ? set_ld : (cnt_d == 2'd0) ? 1'b0 : ld_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= 2'd0;
      ld_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      ld_q  <= ld_d;
    end
  end
  assign cnt = cnt_q;
  assign ld  = ld_q;
endmodule

// File: rtl/load_use_scoreboard.sv
// load_use_scoreboard: stalls ID for one cycle when a used source is produced by a load in EX.
// Optional stall_cycles performance counter enabled by HAZARD_PERF_CNT_EN.
module load_use_scoreboard import riscv_pkg::*; #(
  parameter int NUM_REGS   = 32,
  parameter int PIPE_DEPTH = PIPE_DEPTH_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        id_valid,
  input  logic [6:0]  id_opcode,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  input  logic [4:0]  id_rd,
  input  logic        id_reg_write,
  input  logic        id_mem_read,
  input  logic        flush,
  input  logic        hold,
  output logic        stall,
  output logic        bubble
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0] stall_cycles
`endif
);
  localparam logic [1:0] FULL = 2'(PIPE_DEPTH);
  logic [1:0] cnt [NUM_REGS];
  logic       ld  [NUM_REGS];
  src_use_t   src;
  logic       hz1, hz2, issue;
  assign cnt[0] = 2'd0;
  assign ld[0]  = 1'b0;
  for (genvar i = 1; i < NUM_REGS; i++) begin : g_ent
    scoreboard_entry #(.PIPE_DEPTH(PIPE_DEPTH)) u_ent (
      .clk    (clk),
      .rst    (rst),
      .set    (issue && id_rd == 5'(i)),
      .set_ld (id_mem_read),
      .dec    (!hold),
      .kill   (flush && !hold),
      .cnt    (cnt[i]),
      .ld     (ld[i])
    );
  end
  // ALU producers are forwarded, so only a load sitting in EX forces a stall
  always_comb begin
    src    = decode_src(id_opcode);
    hz1    = src.rs1 && ld[id_rs1] && cnt[id_rs1] == FULL;
    hz2    = src.rs2 && ld[id_rs2] && cnt[id_rs2] == FULL;
    stall  = id_valid && (hz1 || hz2);
    bubble = stall;
    issue  = id_valid && !stall && !hold && !flush && id_reg_write && id_rd != 5'd0;
  end
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cycles_q, stall_cycles_d;
  always_comb stall_cycles_d = (stall && !hold && stall_cycles_q != '1) ? stall_cycles_q + 32'd1 : stall_cycles_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) stall_cycles_q <= 32'd0;
    else     stall_cycles_q <= stall_cycles_d;
  end
  assign stall_cycles = stall_cycles_q;
`endif
endmodule

// File: tb/tb_load_use_scoreboard.sv
// tb_load_use_scoreboard: directed vector table plus reset and perf-counter sequences.
module tb_load_use_scoreboard;
  import riscv_pkg::*;
  localparam logic [6:0] OP_LUI = 7'b0110111;
  logic clk = 1'b0, rst = 1'b1;
  logic id_valid = 1'b0, id_reg_write = 1'b0, id_mem_read = 1'b0, flush = 1'b0, hold = 1'b0;
  logic [6:0] id_opcode = 7'd0;
  logic [4:0] id_rs1 = 5'd0, id_rs2 = 5'd0, id_rd = 5'd0;
  logic stall, bubble;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cycles;
`endif
  int pass_n = 0, tot_n = 0;
  always #5 clk = ~clk;
  load_use_scoreboard dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_opcode(id_opcode),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .id_reg_write(id_reg_write),
    .id_mem_read(id_mem_read), .flush(flush), .hold(hold), .stall(stall), .bubble(bubble)
`ifdef HAZARD_PERF_CNT_EN
    , .stall_cycles(stall_cycles)
`endif
  );
  typedef struct {
    logic v; logic [6:0] op; logic [4:0] rs1, rs2, rd;
    logic rw, mr, fl, hd, es; logic [1:0] ec5;
  } vec_t;
  vec_t tv[$];
  function automatic vec_t mk(logic v, logic [6:0] op, logic [4:0] rs1, logic [4:0] rs2, logic [4:0] rd,
                              logic rw, logic mr, logic fl, logic hd, logic es, logic [1:0] ec5);
    vec_t t;
    t.v = v; t.op = op; t.rs1 = rs1; t.rs2 = rs2; t.rd = rd;
    t.rw = rw; t.mr = mr; t.fl = fl; t.hd = hd; t.es = es; t.ec5 = ec5;
    return t;
  endfunction
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tot_n++;
    if (act === exp) pass_n++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask
  task automatic drive(input vec_t t);
    id_valid = t.v; id_opcode = t.op; id_rs1 = t.rs1; id_rs2 = t.rs2; id_rd = t.rd;
    id_reg_write = t.rw; id_mem_read = t.mr; flush = t.fl; hold = t.hd;
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  initial begin
    //                 v  op         rs1 rs2 rd  rw mr fl hd stall cnt5
    tv.push_back(mk(1, OP_LOAD,   1,  0,  5,  1, 1, 0, 0, 0, 0)); // lw x5
    tv.push_back(mk(1, OP_R,      5,  7,  6,  1, 0, 0, 0, 1, 3)); // add x6,x5,x7 stalls
    tv.push_back(mk(1, OP_R,      5,  7,  6,  1, 0, 0, 0, 0, 2)); // add proceeds
    tv.push_back(mk(1, OP_R,      1,  2,  5,  1, 0, 0, 0, 0, 1)); // add x5 reissues
    tv.push_back(mk(1, OP_R,      5,  5,  6,  1, 0, 0, 0, 0, 3)); // sub x6,x5,x5
    tv.push_back(mk(0, OP_R,      0,  0,  0,  0, 0, 0, 0, 0, 2));
    tv.push_back(mk(1, OP_LOAD,   2,  0,  5,  1, 1, 0, 0, 0, 1)); // lw x5
    tv.push_back(mk(0, OP_R,      0,  0,  0,  0, 0, 1, 0, 0, 3)); // flush kills it
    tv.push_back(mk(1, OP_R,      5,  1,  6,  1, 0, 0, 0, 0, 0)); // add x6,x5,x1
    tv.push_back(mk(1, OP_LOAD,   2,  0,  5,  1, 1, 0, 0, 0, 0)); // lw x5
    tv.push_back(mk(1, OP_STORE,  2,  5,  0,  0, 0, 0, 1, 1, 3)); // sw x5 under hold x4
    tv.push_back(mk(1, OP_STORE,  2,  5,  0,  0, 0, 0, 1, 1, 3));
    tv.push_back(mk(1, OP_STORE,  2,  5,  0,  0, 0, 0, 1, 1, 3));
    tv.push_back(mk(1, OP_STORE,  2,  5,  0,  0, 0, 0, 1, 1, 3));
    tv.push_back(mk(1, OP_STORE,  2,  5,  0,  0, 0, 0, 0, 1, 3)); // one more after hold
    tv.push_back(mk(1, OP_STORE,  2,  5,  0,  0, 0, 0, 0, 0, 2));
    tv.push_back(mk(1, OP_LOAD,   1,  0,  0,  1, 1, 0, 0, 0, 1)); // lw x0
    tv.push_back(mk(1, OP_R,      0,  0,  1,  1, 0, 0, 0, 0, 0)); // add x1,x0,x0
    tv.push_back(mk(1, OP_LOAD,   1,  0,  9,  1, 1, 0, 0, 0, 0)); // lw x9
    tv.push_back(mk(1, OP_LUI,    9,  9,  3,  1, 0, 0, 0, 0, 0)); // lui x3
    tv.push_back(mk(1, OP_LOAD,   0,  0, 10,  1, 1, 0, 0, 0, 0)); // lw x10
    tv.push_back(mk(1, OP_JALR,  10, 10,  1,  1, 0, 0, 0, 1, 0)); // jalr uses rs1
    tv.push_back(mk(1, OP_IALU,  10,  0, 11,  1, 0, 0, 0, 0, 0));
    tv.push_back(mk(1, OP_LOAD,   0,  0, 12,  1, 1, 0, 0, 0, 0)); // lw x12
    tv.push_back(mk(1, OP_BRANCH, 0, 12,  0,  0, 0, 0, 0, 1, 0)); // beq uses rs2
    tv.push_back(mk(1, OP_BRANCH, 0, 12,  0,  0, 0, 0, 0, 0, 0));
    tv.push_back(mk(1, OP_LOAD,   0,  0, 13,  1, 1, 0, 0, 0, 0)); // lw x13
    tv.push_back(mk(1, OP_IALU,   1, 13, 14,  1, 0, 0, 0, 0, 0)); // addi ignores rs2 field
    tv.push_back(mk(1, OP_LOAD,   1,  0,  7,  1, 1, 1, 0, 0, 0)); // flush blocks issue
    tv.push_back(mk(1, OP_R,      7,  7,  8,  1, 0, 0, 0, 0, 0));
    #1;
    drive(mk(1, OP_R, 5, 7, 6, 1, 0, 0, 0, 0, 0));
    #1;
    chk("reset_stall", stall, 0);
    chk("reset_bubble", bubble, 0);
    chk("reset_cnt5", dut.cnt[5], 0);
`ifdef HAZARD_PERF_CNT_EN
    chk("reset_perf", stall_cycles, 0);
`endif
    tick();
    tick();
    rst = 1'b0;
    foreach (tv[i]) begin
      drive(tv[i]);
      #1;
      chk($sformatf("v%0d_stall", i), stall, tv[i].es);
      chk($sformatf("v%0d_bubble", i), bubble, tv[i].es);
      chk($sformatf("v%0d_cnt5", i), dut.cnt[5], tv[i].ec5);
      tick();
    end
    drive(mk(0, OP_R, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    repeat (4) tick();
    // reset arriving mid-stall releases it at once
    drive(mk(1, OP_LOAD, 1, 0, 5, 1, 1, 0, 0, 0, 0));
    tick();
    drive(mk(1, OP_R, 5, 7, 6, 1, 0, 0, 0, 0, 0));
    #1;
    chk("pre_rst_stall", stall, 1);
    rst = 1'b1;
    #1;
    chk("mid_rst_stall", stall, 0);
    chk("mid_rst_bubble", bubble, 0);
    chk("mid_rst_cnt5", dut.cnt[5], 0);
    chk("mid_rst_ld5", dut.ld[5], 0);
`ifdef HAZARD_PERF_CNT_EN
    chk("mid_rst_perf", stall_cycles, 0);
`endif
    tick();
    #1;
    chk("rst_hold_stall", stall, 0);
    rst = 1'b0;
    tick();
    for (int p = 0; p < 3; p++) begin
      drive(mk(1, OP_LOAD, 1, 0, 5, 1, 1, 0, 0, 0, 0));
      tick();
      drive(mk(1, OP_R, 5, 7, 6, 1, 0, 0, 0, 0, 0));
      #1;
      chk($sformatf("pair%0d_stall", p), stall, 1);
      tick();
      chk($sformatf("pair%0d_release", p), stall, 0);
      tick();
    end
`ifdef HAZARD_PERF_CNT_EN
    chk("perf_three_pairs", stall_cycles, 3);
`endif
    $display("%0d/%0d checks passed", pass_n, tot_n);
    $finish;
  end
endmodule
